binario_scan_ctrl: RTL and testbench

//  Sequencer for the 5-bit-code -> 7-bit LED converter. Drives the converter input

---
 rtl/binario_scan_ctrl.sv | 132 +++++++++++++
 tb/tb_binario_scan_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/binario_scan_ctrl.sv
// Sequencer for the 5-bit code -> 7-bit LED converter.
// Feeds the converter from the switches (on a button press) or from a slow
// auto-scan counter, and captures the converter result into a stable LED register.
module binario_scan_ctrl #(
    parameter int PRESCALE = 50000000,  // HOLD cycles per scan step, >= 1
    parameter int SCAN_MAX = 31         // last scanned code before wrapping to 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] sw_code,
    input  logic       load_n,
    input  logic       scan_en,
    output logic [4:0] conv_in,
    input  logic [6:0] conv_out,
    output logic [6:0] led,
    output logic [4:0] code_shown,
    output logic       valid,
    output logic       busy
);

    localparam int PW = $clog2(PRESCALE + 1);
    localparam logic [PW-1:0] PS_LAST   = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] PS_ONE    = PW'(1);
    localparam logic [4:0]    CODE_LAST = 5'(SCAN_MAX);

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, HOLD} state_t;

    state_t        state_q, state_d;
    logic [4:0]    code_q, code_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [6:0]    led_q, led_d;
    logic [4:0]    shown_q, shown_d;
    logic          valid_q, valid_d;
    logic          s1_q, s2_q, s3_q;
    logic          load_p;

    // Button synchroniser; idles high so a button held through reset still
    // produces one press once reset is released.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
            s3_q <= 1'b1;
        end else begin
            s1_q <= load_n;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // One-cycle pulse on the synchronised falling edge of load_n.
    assign load_p = s3_q & ~s2_q;

    // State, code, prescaler and LED result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            code_q  <= '0;
            presc_q <= '0;
            led_q   <= '0;
            shown_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            presc_q <= presc_d;
            led_q   <= led_d;
            shown_q <= shown_d;
            valid_q <= valid_d;
        end
    end

    // Next-state logic: start conversions on load/scan, advance the scan on tick.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        presc_d = presc_q;
        led_d   = led_q;
        shown_d = shown_q;
        valid_d = valid_q;
        unique case (state_q)
            IDLE: begin
                if (scan_en) begin
                    code_d  = '0;
                    presc_d = '0;
                    state_d = DRIVE;
                end else if (load_p) begin
                    code_d  = sw_code;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                // conv_in has been stable one cycle; the converter has settled.
                state_d = SAMPLE;
            end
            SAMPLE: begin
                led_d   = conv_out;
                shown_d = code_q;
                valid_d = 1'b1;
                state_d = HOLD;
            end
            HOLD: begin
                if (!scan_en) begin
                    presc_d = '0;
                    if (load_p) begin
                        code_d  = sw_code;
                        state_d = DRIVE;
                    end
                end else if (load_p) begin
                    // A press during scanning restarts the scan; it beats a tick.
                    code_d  = '0;
                    presc_d = '0;
                    state_d = DRIVE;
                end else if (presc_q == PS_LAST) begin
                    presc_d = '0;
                    code_d  = (code_q == CODE_LAST) ? 5'd0 : code_q + 5'd1;
                    state_d = DRIVE;
                end else begin
                    presc_d = presc_q + PS_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign conv_in    = code_q;
    assign led        = led_q;
    assign code_shown = shown_q;
    assign valid      = valid_q;
    assign busy       = (state_q == DRIVE) || (state_q == SAMPLE);

endmodule

// File: tb/tb_binario_scan_ctrl.sv
// Bench for binario_scan_ctrl: two instances (PRESCALE=4/SCAN_MAX=31 and
// PRESCALE=1/SCAN_MAX=9) share stimulus and are compared every cycle against
// a countdown-style behavioural model, plus directed literal checks.
module tb_binario_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] sw_code;
    logic       load_n;
    logic       scan_en;

    logic [4:0] conv_in_a, code_shown_a, conv_in_b, code_shown_b;
    logic [6:0] conv_out_a, led_a, conv_out_b, led_b;
    logic       valid_a, busy_a, valid_b, busy_b;

    int tests = 0;
    int fails = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    // Converter stubs.
    assign conv_out_a = {2'b10, conv_in_a};
    assign conv_out_b = {2'b10, conv_in_b};

    binario_scan_ctrl #(.PRESCALE(4), .SCAN_MAX(31)) dut_a (
        .clk(clk), .rst_n(rst_n), .sw_code(sw_code), .load_n(load_n), .scan_en(scan_en),
        .conv_in(conv_in_a), .conv_out(conv_out_a), .led(led_a),
        .code_shown(code_shown_a), .valid(valid_a), .busy(busy_a)
    );

    binario_scan_ctrl #(.PRESCALE(1), .SCAN_MAX(9)) dut_b (
        .clk(clk), .rst_n(rst_n), .sw_code(sw_code), .load_n(load_n), .scan_en(scan_en),
        .conv_in(conv_in_b), .conv_out(conv_out_b), .led(led_b),
        .code_shown(code_shown_b), .valid(valid_b), .busy(busy_b)
    );

    // Behavioural model: a conversion is a 2-cycle countdown, a result lands
    // when it expires; the scan waits presc cycles between conversions.
    typedef struct {
        bit       in_hold;
        int       busy_left;
        int       code;
        int       hold_cnt;
        int       led;
        int       shown;
        bit       valid;
        bit [2:0] hist;   // last three load_n samples, [0] newest
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t step(mdl_t m, logic rst, logic ln, logic se,
                                  logic [4:0] sw, int presc, int smax);
        mdl_t n;
        bit   press;
        n = m;
        if (!rst) begin
            n.in_hold = 0; n.busy_left = 0; n.code = 0; n.hold_cnt = 0;
            n.led = 0; n.shown = 0; n.valid = 0; n.hist = 3'b111;
            return n;
        end
        press  = m.hist[2] & ~m.hist[1];
        n.hist = {m.hist[1:0], ln};
        if (m.busy_left == 2) begin
            n.busy_left = 1;
        end else if (m.busy_left == 1) begin
            n.busy_left = 0;
            n.led       = 64 + m.code;
            n.shown     = m.code;
            n.valid     = 1;
            n.in_hold   = 1;
        end else if (!m.in_hold) begin
            if (se) begin
                n.code = 0; n.hold_cnt = 0; n.busy_left = 2;
            end else if (press) begin
                n.code = int'(sw); n.busy_left = 2;
            end
        end else if (!se) begin
            n.hold_cnt = 0;
            if (press) begin
                n.code = int'(sw); n.busy_left = 2;
            end
        end else if (press) begin
            n.code = 0; n.hold_cnt = 0; n.busy_left = 2;
        end else if (m.hold_cnt == presc - 1) begin
            n.hold_cnt  = 0;
            n.code      = (m.code == smax) ? 0 : (m.code + 1) % 32;
            n.busy_left = 2;
        end else begin
            n.hold_cnt = m.hold_cnt + 1;
        end
        return n;
    endfunction

    // Advance both models on each rising edge with the inputs the DUTs see.
    always @(posedge clk) begin
        ma = step(ma, rst_n, load_n, scan_en, sw_code, 4, 31);
        mb = step(mb, rst_n, load_n, scan_en, sw_code, 1, 9);
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("a_led",   int'(led_a),        ma.led);
            chk("a_shown", int'(code_shown_a), ma.shown);
            chk("a_conv",  int'(conv_in_a),    ma.code);
            chk("a_valid", int'(valid_a),      int'(ma.valid));
            chk("a_busy",  int'(busy_a),       int'(ma.busy_left != 0));
            chk("b_led",   int'(led_b),        mb.led);
            chk("b_shown", int'(code_shown_b), mb.shown);
            chk("b_conv",  int'(conv_in_b),    mb.code);
            chk("b_valid", int'(valid_b),      int'(mb.valid));
            chk("b_busy",  int'(busy_b),       int'(mb.busy_left != 0));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int  exp_busy [6];
        int  ea, eb, ta, tb_last, na, nb, cyc, budget;
        bit  pa, pb, first_a, first_b, found;

        exp_busy = '{0, 0, 1, 1, 0, 0};
        rst_n = 1'b0; load_n = 1'b0; scan_en = 1'b0; sw_code = 5'd0;

        // T1: reset held 3 cycles with the button down.
        @(negedge clk);
        cmp_en = 1'b1;
        tick(2);
        chk("t1_rst_led",   int'(led_a), 0);
        chk("t1_rst_shown", int'(code_shown_a), 0);
        chk("t1_rst_conv",  int'(conv_in_a), 0);
        chk("t1_rst_valid", int'(valid_a), 0);
        chk("t1_rst_busy",  int'(busy_a), 0);
        rst_n = 1'b1;
        tick(6);
        chk("t1_post_valid", int'(valid_a), 1);
        chk("t1_post_led",   int'(led_a), 7'b1000000);
        load_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("t1_no_second", int'(busy_a), 0);
        end

        // T2: manual load of 19, button low for 6 cycles.
        sw_code = 5'd19;
        load_n  = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick(1);
            chk($sformatf("t2_busy_e%0d", k), int'(busy_a), exp_busy[k]);
            chk($sformatf("t2_led_e%0d", k), int'(led_a), (k < 4) ? 7'b1000000 : 7'b1010011);
        end
        chk("t2_shown", int'(code_shown_a), 19);
        load_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("t2_one_conv", int'(busy_a), 0);
        end

        // T3/T4: scan from IDLE; A steps every 6 cycles up to 31, B every 3 up to 9.
        rst_n = 1'b0; scan_en = 1'b1;
        tick(2);
        rst_n = 1'b1;
        ea = 0; eb = 0; na = 0; nb = 0; cyc = 0; ta = 0; tb_last = 0;
        pa = 1'b0; pb = 1'b0; first_a = 1'b1; first_b = 1'b1;
        while (na < 34 && cyc < 400) begin
            tick(1);
            cyc++;
            if (pa && !busy_a) begin
                chk("t3_code", int'(code_shown_a), ea);
                chk("t3_led", int'(led_a), 64 + ea);
                if (!first_a) chk("t3_period", cyc - ta, 6);
                first_a = 1'b0; ta = cyc; ea = (ea + 1) % 32; na++;
            end
            if (pb && !busy_b) begin
                chk("t4_code", int'(code_shown_b), eb);
                if (!first_b) chk("t4_period", cyc - tb_last, 3);
                first_b = 1'b0; tb_last = cyc; eb = (eb == 9) ? 0 : eb + 1; nb++;
            end
            pa = busy_a; pb = busy_b;
        end
        chk("t3_done", na, 34);

        // T5: press lands on the tick cycle at code 7 -> restart at 0.
        found = 1'b0; budget = 0; pa = busy_a;
        while (!found && budget < 400) begin
            tick(1);
            budget++;
            if (pa && !busy_a && code_shown_a == 5'd7) found = 1'b1;
            pa = busy_a;
        end
        chk("t5_found_7", int'(found), 1);
        tick(1);
        load_n = 1'b0;
        for (int k = 2; k <= 12; k++) begin
            tick(1);
            chk($sformatf("t5_shown_s%0d", k), int'(code_shown_a), (k < 6) ? 7 : ((k < 12) ? 0 : 1));
            if (k == 8) load_n = 1'b1;
        end

        // T6: reset during DRIVE of a manual load of 5 after showing 19.
        scan_en = 1'b0; rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1; sw_code = 5'd19; load_n = 1'b0;
        tick(6);
        load_n = 1'b1;
        tick(4);
        chk("t6_prior_led", int'(led_a), 7'b1010011);
        sw_code = 5'd5; load_n = 1'b0;
        tick(3);
        chk("t6_in_drive", int'(busy_a), 1);
        rst_n = 1'b0; load_n = 1'b1;
        tick(1);
        chk("t6_rst_led", int'(led_a), 0);
        chk("t6_rst_valid", int'(valid_a), 0);
        tick(1);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("t6_no_update", int'(valid_a), 0);
        end

        // Randomised phase, checked by the per-cycle model comparison.
        for (int i = 0; i < 2500; i++) begin
            tick(1);
            if ($urandom_range(0, 7) == 0) load_n = ~load_n;
            if ($urandom_range(0, 149) == 0) scan_en = ~scan_en;
            sw_code = 5'($urandom);
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 399) == 0) rst_n = 1'b0;
        end

        tick(1);
        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
